// File: rtl/noc_credit_link_tx.sv
// Transmit end of a credit-based router-to-router link.
// Turns a valid/ready flit stream into registered send pulses gated by downstream credits.
module noc_credit_link_tx #(
    parameter int FLIT_WIDTH        = 32,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 2,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                    clk_noc,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FLIT_WIDTH-1:0]   in_data,
    input  logic [DEST_WIDTH-1:0]   in_dest,
    input  logic                    in_is_tail,
    output logic [FLIT_WIDTH-1:0]   data_out,
    output logic [DEST_WIDTH-1:0]   dest_out,
    output logic                    is_tail_out,
    output logic                    send_out,
    input  logic                    credit_in,
    output logic [CREDIT_WIDTH-1:0] credits_avail,
    output logic                    pkt_active,
    output logic                    err_credit_overflow
);

    typedef enum logic [0:0] {
        S_IDLE,
        S_BODY
    } state_e;

    localparam logic [CREDIT_WIDTH-1:0] CRED_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] CRED_ONE = CREDIT_WIDTH'(1);

    state_e                  state_q;
    logic                    pkt_active_q;
    logic [DEST_WIDTH-1:0]   dest_hold_q;

    logic [CREDIT_WIDTH-1:0] credits_q;
    logic [CREDIT_WIDTH-1:0] credits_d;

    logic                    send_q;
    logic [FLIT_WIDTH-1:0]   data_q;
    logic [DEST_WIDTH-1:0]   dest_q;
    logic                    tail_q;
    logic                    err_ovf_q;

    logic                    accept;
    logic                    cred_full;
    logic                    overflow;
    logic [DEST_WIDTH-1:0]   dest_sel;

    // Ready depends only on the registered count; forced low during reset.
    assign in_ready  = rst_n & (credits_q != '0);
    assign accept    = in_valid & in_ready;
    assign cred_full = (credits_q == CRED_MAX);
    assign overflow  = credit_in & ~accept & cred_full;

    // Head flits carry their own dest; body flits reuse the latched head dest.
    assign dest_sel = (state_q == S_IDLE) ? in_dest : dest_hold_q;

    // Next credit count: spend on accept, refund on credit_in, saturate at depth.
    always_comb begin
        credits_d = credits_q;
        unique case ({accept, credit_in})
            2'b10: credits_d = credits_q - CRED_ONE;
            2'b01: begin
                if (!cred_full) begin
                    credits_d = credits_q + CRED_ONE;
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    // Credit counter register.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            credits_q <= CRED_MAX;
        end else begin
            credits_q <= credits_d;
        end
    end

    // Packet framing FSM with registered pkt_active and held head dest.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pkt_active_q <= 1'b0;
            dest_hold_q  <= '0;
        end else if (accept) begin
            unique case (state_q)
                S_IDLE: begin
                    dest_hold_q <= in_dest;
                    if (!in_is_tail) begin
                        state_q      <= S_BODY;
                        pkt_active_q <= 1'b1;
                    end
                end
                S_BODY: begin
                    if (in_is_tail) begin
                        state_q      <= S_IDLE;
                        pkt_active_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    pkt_active_q <= 1'b0;
                end
            endcase
        end
    end

    // Link output registers: pulse send, hold payload fields between flits.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            send_q <= 1'b0;
            data_q <= '0;
            dest_q <= '0;
            tail_q <= 1'b0;
        end else begin
            send_q <= accept;
            if (accept) begin
                data_q <= in_data;
                dest_q <= dest_sel;
                tail_q <= in_is_tail;
            end
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf_q <= 1'b0;
        end else if (overflow) begin
            err_ovf_q <= 1'b1;
        end
    end

    assign send_out            = send_q;
    assign data_out            = data_q;
    assign dest_out            = dest_q;
    assign is_tail_out         = tail_q;
    assign credits_avail       = credits_q;
    assign pkt_active          = pkt_active_q;
    assign err_credit_overflow = err_ovf_q;

endmodule

// File: tb/tb_noc_credit_link_tx.sv
// Directed bench for noc_credit_link_tx.
// Expected values are hand-derived per cycle.
module tb_noc_credit_link_tx;

    logic        clk_noc = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [5:0]  in_dest;
    logic        in_is_tail;
    logic [31:0] data_out;
    logic [5:0]  dest_out;
    logic        is_tail_out;
    logic        send_out;
    logic        credit_in;
    logic [1:0]  credits_avail;
    logic        pkt_active;
    logic        err_credit_overflow;

    int total = 0;
    int bad   = 0;

    noc_credit_link_tx #(
        .FLIT_WIDTH(32),
        .DEST_WIDTH(6),
        .FLIT_BUFFER_DEPTH(2)
    ) dut (
        .clk_noc(clk_noc),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_dest(in_dest),
        .in_is_tail(in_is_tail),
        .data_out(data_out),
        .dest_out(dest_out),
        .is_tail_out(is_tail_out),
        .send_out(send_out),
        .credit_in(credit_in),
        .credits_avail(credits_avail),
        .pkt_active(pkt_active),
        .err_credit_overflow(err_credit_overflow)
    );

    always #5 clk_noc = ~clk_noc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_noc);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_dest    = '0;
        in_is_tail = 1'b0;
        credit_in  = 1'b0;
        tick();
        tick();
        check("rst_ready", in_ready, 0);
        check("rst_cred", credits_avail, 2);
        check("rst_send", send_out, 0);
        check("rst_data", data_out, 0);
        check("rst_pkt", pkt_active, 0);
        check("rst_err", err_credit_overflow, 0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", in_ready, 1);

        // Burst of single-flit packets with no credits returned
        in_valid   = 1'b1;
        in_data    = 32'hA0;
        in_dest    = 6'h05;
        in_is_tail = 1'b1;
        tick();
        check("b1_send", send_out, 1);
        check("b1_data", data_out, 32'hA0);
        check("b1_dest", dest_out, 6'h05);
        check("b1_cred", credits_avail, 1);
        in_data = 32'hA1;
        tick();
        check("b2_send", send_out, 1);
        check("b2_data", data_out, 32'hA1);
        check("b2_cred", credits_avail, 0);
        check("b2_ready", in_ready, 0);
        in_data = 32'hA2;
        tick();
        check("b3_send", send_out, 0);
        check("b3_hold", data_out, 32'hA1);
        tick();
        check("b4_send", send_out, 0);

        // One credit from zero: ready next cycle, one flit out
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        check("c1_ready", in_ready, 1);
        check("c1_cred", credits_avail, 1);
        check("c1_send", send_out, 0);
        in_data = 32'hB0;
        tick();
        check("c2_send", send_out, 1);
        check("c2_data", data_out, 32'hB0);
        check("c2_cred", credits_avail, 0);
        in_valid = 1'b0;

        // 3-flit packet with credits returned every cycle
        credit_in = 1'b1;
        tick();
        check("p0_cred", credits_avail, 1);
        in_valid   = 1'b1;
        in_data    = 32'hC0;
        in_dest    = 6'h15;
        in_is_tail = 1'b0;
        tick();
        check("p1_send", send_out, 1);
        check("p1_dest", dest_out, 6'h15);
        check("p1_tail", is_tail_out, 0);
        check("p1_pkt", pkt_active, 1);
        check("p1_cred", credits_avail, 1);
        in_data = 32'hC1;
        in_dest = 6'h3F;
        tick();
        check("p2_dest", dest_out, 6'h15);
        check("p2_tail", is_tail_out, 0);
        check("p2_pkt", pkt_active, 1);
        check("p2_cred", credits_avail, 1);
        check("p2_ready", in_ready, 1);
        in_data    = 32'hC2;
        in_dest    = 6'h00;
        in_is_tail = 1'b1;
        tick();
        check("p3_send", send_out, 1);
        check("p3_data", data_out, 32'hC2);
        check("p3_dest", dest_out, 6'h15);
        check("p3_tail", is_tail_out, 1);
        check("p3_pkt", pkt_active, 0);
        check("p3_cred", credits_avail, 1);

        // Refill, then overflow
        in_valid = 1'b0;
        tick();
        check("o0_cred", credits_avail, 2);
        check("o0_err", err_credit_overflow, 0);
        tick();
        check("o1_cred", credits_avail, 2);
        check("o1_err", err_credit_overflow, 1);
        credit_in  = 1'b0;
        in_valid   = 1'b1;
        in_data    = 32'hD0;
        in_dest    = 6'h2A;
        in_is_tail = 1'b1;
        tick();
        check("o2_send", send_out, 1);
        check("o2_dest", dest_out, 6'h2A);
        check("o2_err", err_credit_overflow, 1);
        check("o2_cred", credits_avail, 1);
        in_valid = 1'b0;
        tick();
        check("o3_err", err_credit_overflow, 1);

        // Reset in the middle of a packet
        in_valid   = 1'b1;
        in_data    = 32'hE0;
        in_dest    = 6'h11;
        in_is_tail = 1'b0;
        tick();
        check("r0_pkt", pkt_active, 1);
        check("r0_cred", credits_avail, 0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("r1_send", send_out, 0);
        check("r1_cred", credits_avail, 2);
        check("r1_pkt", pkt_active, 0);
        check("r1_ready", in_ready, 0);
        check("r1_err", err_credit_overflow, 0);
        tick();
        rst_n = 1'b1;

        // New head after reset, then zero-credit stall mid-packet
        in_valid   = 1'b1;
        in_data    = 32'hF0;
        in_dest    = 6'h22;
        in_is_tail = 1'b0;
        tick();
        check("h1_dest", dest_out, 6'h22);
        check("h1_pkt", pkt_active, 1);
        check("h1_cred", credits_avail, 1);
        in_data = 32'hF1;
        in_dest = 6'h33;
        tick();
        check("h2_dest", dest_out, 6'h22);
        check("h2_ready", in_ready, 0);
        in_data    = 32'hF2;
        in_dest    = 6'h30;
        in_is_tail = 1'b1;
        credit_in  = 1'b1;
        tick();
        credit_in = 1'b0;
        check("s1_send", send_out, 0);
        check("s1_cred", credits_avail, 1);
        check("s1_ready", in_ready, 1);
        check("s1_pkt", pkt_active, 1);
        tick();
        in_valid = 1'b0;
        check("s2_send", send_out, 1);
        check("s2_data", data_out, 32'hF2);
        check("s2_dest", dest_out, 6'h22);
        check("s2_tail", is_tail_out, 1);
        check("s2_pkt", pkt_active, 0);
        check("s2_cred", credits_avail, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
